// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by the IF and MEM stages; splits 1/2/4-byte accesses into byte cycles.
// Define MEM_CTRL_FETCH_BUF_EN to add a one-entry fetch buffer that serves repeat fetches without RAM cycles.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              if_stall_req,
  output logic              mem_stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              owner_if_q, owner_if_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
`ifdef MEM_CTRL_FETCH_BUF_EN
  logic              fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0] fb_tag_q, fb_tag_d;
  logic [31:0]       fb_word_q, fb_word_d;
`endif

  // step = edge number E(k) after the accept edge; read bytes land two edges after their address
  logic [2:0] step;
  logic [1:0] rd_idx;
  logic [1:0] wr_idx;
  logic       unused_hi;

  assign step      = cnt_q + 3'd1;
  assign rd_idx    = 2'(step - 3'd2);
  assign wr_idx    = step[1:0];
  assign unused_hi = &{1'b0, if_addr[31:ADDR_W], mem_addr[31:ADDR_W], wdata_q[7:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    owner_if_d  = owner_if_q;
    data_d      = data_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
`ifdef MEM_CTRL_FETCH_BUF_EN
    fb_valid_d  = fb_valid_q;
    fb_tag_d    = fb_tag_q;
    fb_word_d   = fb_word_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          owner_if_d = 1'b0;
          addr_d     = mem_addr[ADDR_W-1:0];
          wdata_d    = mem_wdata;
          case (mem_size)
            2'd0:    nbytes_d = 3'd1;
            2'd1:    nbytes_d = 3'd2;
            default: nbytes_d = 3'd4;
          endcase
          ram_addr_d = mem_addr[ADDR_W-1:0];
          cnt_d      = 3'd0;
          data_d     = '0;
          if (mem_we) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
            state_d    = S_WR;
          end else begin
            ram_wr_d = 1'b0;
            state_d  = S_RD;
          end
        end else if (if_req) begin
`ifdef MEM_CTRL_FETCH_BUF_EN
          if (fb_valid_q && fb_tag_q == if_addr[ADDR_W-1:0]) begin
            if_data_d = fb_word_q;
            if_done_d = 1'b1;
            state_d   = S_DONE;
          end else
`endif
          begin
            owner_if_d = 1'b1;
            addr_d     = if_addr[ADDR_W-1:0];
            nbytes_d   = 3'd4;
            ram_addr_d = if_addr[ADDR_W-1:0];
            ram_wr_d   = 1'b0;
            cnt_d      = 3'd0;
            data_d     = '0;
            state_d    = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d = step;
        if (step < nbytes_q) ram_addr_d = addr_q + ADDR_W'(step);
        if (step >= 3'd2) data_d[{rd_idx, 3'b000} +: 8] = ram_din;
        if (step == nbytes_q + 3'd1) begin
          state_d = S_DONE;
          if (owner_if_q) begin
            if_done_d = 1'b1;
            if_data_d = data_d;
`ifdef MEM_CTRL_FETCH_BUF_EN
            fb_valid_d = 1'b1;
            fb_tag_d   = addr_q;
            fb_word_d  = data_d;
`endif
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = data_d;
          end
        end
      end
      S_WR: begin
        cnt_d = step;
        if (step < nbytes_q) begin
          ram_addr_d = addr_q + ADDR_W'(step);
          ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
        end else begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
          state_d    = S_DONE;
`ifdef MEM_CTRL_FETCH_BUF_EN
          fb_valid_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      owner_if_q  <= 1'b0;
      data_q      <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_CTRL_FETCH_BUF_EN
      fb_valid_q  <= 1'b0;
      fb_tag_q    <= '0;
      fb_word_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      owner_if_q  <= owner_if_d;
      data_q      <= data_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEM_CTRL_FETCH_BUF_EN
      fb_valid_q  <= fb_valid_d;
      fb_tag_q    <= fb_tag_d;
      fb_word_q   <= fb_word_d;
`endif
    end
  end

  assign if_data       = if_data_q;
  assign if_done       = if_done_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_done      = mem_done_q;
  assign ram_addr      = ram_addr_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = ram_wr_q;
  assign if_stall_req  = if_req & ~if_done_q;
  assign mem_stall_req = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: models a synchronous-read byte RAM and checks latency, data and reset abort.
module tb_mem_ctrl;
  localparam int unsigned ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, mem_req, mem_we;
  logic [31:0]       if_addr, mem_addr, mem_wdata;
  logic [1:0]        mem_size;
  logic [31:0]       if_data, mem_rdata;
  logic              if_done, mem_done, if_stall_req, mem_stall_req;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout, ram_din;
  logic              ram_wr;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;
  int                wr_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wr) begin
      mem[ram_addr] <= ram_dout;
      wr_cnt <= wr_cnt + 1;
    end
    ram_din <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // lat = edges after the accept edge until done is seen (0 = done at accept edge), -1 on timeout
  task automatic access(input logic is_if, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    @(negedge clk);
    if (is_if) begin if_req = 1'b1; if_addr = a; end
    else begin mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd; end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (is_if ? if_done : mem_done) begin
        lat = i;
        rd  = is_if ? if_data : mem_rdata;
        check("done_exclusive", {31'd0, if_done & mem_done}, 32'd0);
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, md_edge, id_edge, wc0;
    logic [31:0] rd;
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    preload(17'h00100, 8'h13); preload(17'h00101, 8'h00);
    preload(17'h00102, 8'h00); preload(17'h00103, 8'h00);
    preload(17'h00104, 8'h77); preload(17'h00000, 8'h12);
    preload(17'h00200, 8'h78); preload(17'h00201, 8'h56);
    preload(17'h00202, 8'h34); preload(17'h00203, 8'h12);
    preload(17'h00402, 8'h5A);
    check("rst_ram_addr",  {15'd0, ram_addr}, 32'd0);
    check("rst_ram_dout",  {24'd0, ram_dout}, 32'd0);
    check("rst_ram_wr",    {31'd0, ram_wr},   32'd0);
    check("rst_if_done",   {31'd0, if_done},  32'd0);
    check("rst_mem_done",  {31'd0, mem_done}, 32'd0);
    check("rst_if_data",   if_data,   32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    access(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, lat, rd);
    check("fetch100_lat", lat, 32'd5);
    check("fetch100_data", rd, 32'h00000013);

    wc0 = wr_cnt;
    access(1'b0, 1'b1, 2'd0, 32'h1FFFF, 32'h000000AB, lat, rd);
    check("sb_lat", lat, 32'd1);
    check("sb_wr_cycles", wr_cnt - wc0, 32'd1);
    check("sb_ram", {24'd0, mem[17'h1FFFF]}, 32'h000000AB);

    preload(17'h1FFFF, 8'h34);
    access(1'b0, 1'b0, 2'd1, 32'h1FFFF, 32'h0, lat, rd);
    check("lh_wrap_lat", lat, 32'd3);
    check("lh_wrap_data", rd, 32'h00001234);

    access(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, lat, rd);
    check("lb_lat", lat, 32'd2);
    check("lb_data", rd, 32'h00000013);
    access(1'b0, 1'b0, 2'd3, 32'h101, 32'h0, lat, rd);
    check("lw_misal_lat", lat, 32'd5);
    check("lw_misal_data", rd, 32'h77000000);

    // simultaneous requests: store must win, fetch follows after DONE->IDLE
    md_edge = -1; id_edge = -1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mem_done && md_edge < 0) begin
        md_edge = i;
        check("arb_if_stall", {31'd0, if_stall_req}, 32'd1);
        check("arb_exclusive", {31'd0, if_done}, 32'd0);
        mem_req = 1'b0;
      end
      if (if_done) begin
        id_edge = i;
        check("arb_fetch_data", if_data, 32'hDEADBEEF);
        check("arb_exclusive2", {31'd0, mem_done}, 32'd0);
        if_req = 1'b0;
        break;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("arb_store_lat", md_edge, 32'd4);
    check("arb_fetch_edge", id_edge, 32'd11);
    @(posedge clk); #1;

    // reset during a word store: rst sampled at E2
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h400; mem_wdata = 32'h11223344;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    check("abort_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("abort_mem_done", {31'd0, mem_done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'd0, mem_done}, 32'd0);
    end
    check("abort_b0", {24'd0, mem[17'h00400]}, 32'h44);
    check("abort_b1", {24'd0, mem[17'h00401]}, 32'h33);
    check("abort_b2", {24'd0, mem[17'h00402]}, 32'h5A);
    access(1'b0, 1'b0, 2'd0, 32'h400, 32'h0, lat, rd);
    check("post_abort_lat", lat, 32'd2);
    check("post_abort_data", rd, 32'h00000044);

    access(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, lat, rd);
    check("fb_first_lat", lat, 32'd5);
    check("fb_first_data", rd, 32'h12345678);
    access(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, lat, rd);
`ifdef MEM_CTRL_FETCH_BUF_EN
    check("fb_hit_lat", lat, 32'd0);
`else
    check("fb_hit_lat", lat, 32'd5);
`endif
    check("fb_hit_data", rd, 32'h12345678);
    access(1'b0, 1'b1, 2'd0, 32'h500, 32'h00000001, lat, rd);
    check("fb_store_lat", lat, 32'd1);
    access(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, lat, rd);
    check("fb_refetch_lat", lat, 32'd5);
    check("fb_refetch_data", rd, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
